// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pattern generator:
//   - mode_e        : pattern-select encoding driven on the 'mode' input
//   - LFSR_TAPS     : Galois feedback mask for the 32-bit noise LFSR
//   - DEF_*         : default 640x480@60 timing (pixel clocks / lines)
//   - lfsrStep()    : one right-shift step of the Galois LFSR
// ---------------------------------------------------------------------------
package vga_pkg;

    // Pattern select encoding
    typedef enum logic [1:0] {
        MODE_NOISE = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_e;

    // Galois feedback mask applied when the bit shifted out is 1
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Default 640x480@60 timing
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // One step of the right-shifting Galois LFSR
    function automatic logic [31:0] lfsrStep(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// ---------------------------------------------------------------------------
// lfsr32
// 32-bit Galois LFSR used as the noise source.
//   clock   in   pixel clock
//   reset   in   asynchronous, active-high; loads RESET_VALUE
//   load    in   replace the state with 'seed'
//   advance in   step the LFSR once
//   seed    in   reload value
//   value   out  current LFSR state
// When load and advance are both high the step is taken from the seed, so
// the pixel that triggered the reload consumes the seed and the next pixel
// sees its successor.
// ---------------------------------------------------------------------------
module lfsr32
    import vga_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RESET_VALUE;
        end else if (advance) begin
            r_state <= lfsrStep(load ? seed : r_state);
        end else if (load) begin
            r_state <= seed;
        end
    end

    assign value = r_state;

endmodule

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// Parametrised VGA source with programmable sync timing and four test
// patterns (LFSR noise, colour bars, checkerboard, grey ramp).
//   clock        in   pixel clock
//   reset        in   asynchronous, active-high
//   mode         in   pattern select (see vga_pkg::mode_e)
//   freeze       in   1 = reload the LFSR each frame (static noise)
//   R, G, B      out  pixel colour, COLOR_BITS each
//   HS, VS       out  syncs, active level HS_POL / VS_POL
//   de           out  active-video flag
//   x, y         out  pixel column / row
//   frame_start  out  one-cycle pulse with pixel (0,0)
//   frame        out  frame counter
// All outputs are registered together: counters at (h,v) in one cycle
// appear as the outputs for (h,v) on the next cycle.
// ---------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int          H_VISIBLE  = DEF_H_VISIBLE,
    parameter int          H_FRONT    = DEF_H_FRONT,
    parameter int          H_SYNC     = DEF_H_SYNC,
    parameter int          H_BACK     = DEF_H_BACK,
    parameter int          V_VISIBLE  = DEF_V_VISIBLE,
    parameter int          V_FRONT    = DEF_V_FRONT,
    parameter int          V_SYNC     = DEF_V_SYNC,
    parameter int          V_BACK     = DEF_V_BACK,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int          COLOR_BITS = 4,
    parameter int          CELL_LOG2  = 3,
    parameter int          RAMP_SHIFT = 5,
    parameter logic [31:0] LFSR_SEED  = 32'hACE11234
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  freeze,
    output logic [COLOR_BITS-1:0] R,
    output logic [COLOR_BITS-1:0] G,
    output logic [COLOR_BITS-1:0] B,
    output logic                  HS,
    output logic                  VS,
    output logic                  de,
    output logic [15:0]           x,
    output logic [15:0]           y,
    output logic                  frame_start,
    output logic [15:0]           frame
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int BAR_W   = H_VISIBLE / 8;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS16  = 16'(H_VISIBLE);
    localparam logic [15:0] V_VIS16  = 16'(V_VISIBLE);
    localparam logic [15:0] HS_FIRST = 16'(H_VISIBLE + H_FRONT);
    localparam logic [15:0] HS_LAST  = 16'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST = 16'(V_VISIBLE + V_FRONT);
    localparam logic [15:0] VS_LAST  = 16'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    localparam logic [COLOR_BITS-1:0] FULL = '1;

    generate
        if (3 * COLOR_BITS > 32) begin : g_badColorBits
            $error("vga_pattern_gen: 3*COLOR_BITS must not exceed 32");
        end
        if (H_VISIBLE < 8) begin : g_badHVisible
            $error("vga_pattern_gen: H_VISIBLE must be at least 8");
        end
    endgenerate

    logic [15:0] r_h;
    logic [15:0] r_v;
    logic [15:0] r_barCnt;
    logic [2:0]  r_barIdx;
    logic [15:0] r_frameCnt;
    mode_e       r_modeQ;
    logic        r_freezeQ;

    logic        w_hLast;
    logic        w_vLast;
    logic        w_origin;
    logic        w_visible;
    logic        w_hsActive;
    logic        w_vsActive;
    mode_e       w_modeEff;
    logic        w_freezeEff;
    logic        w_lfsrLoad;
    logic [31:0] w_lfsrValue;
    logic [31:0] w_lfsrCur;
    logic [31:0] w_hWide;
    logic [31:0] w_vWide;
    logic [2:0]  w_barColor;
    logic        w_checkBit;
    logic [COLOR_BITS-1:0] w_r;
    logic [COLOR_BITS-1:0] w_g;
    logic [COLOR_BITS-1:0] w_b;

    assign w_hLast    = (r_h == H_LAST);
    assign w_vLast    = (r_v == V_LAST);
    assign w_origin   = (r_h == 16'd0) && (r_v == 16'd0);
    assign w_visible  = (r_h < H_VIS16) && (r_v < V_VIS16);
    assign w_hsActive = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    assign w_vsActive = (r_v >= VS_FIRST) && (r_v <= VS_LAST);

    // The origin pixel already belongs to the new frame, so it uses the
    // live inputs that are being captured on this very cycle.
    assign w_modeEff   = w_origin ? mode_e'(mode) : r_modeQ;
    assign w_freezeEff = w_origin ? freeze : r_freezeQ;

    // Raster counters: h runs across the line, v advances on each h wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h <= 16'd0;
            r_v <= 16'd0;
        end else if (w_hLast) begin
            r_h <= 16'd0;
            r_v <= w_vLast ? 16'd0 : r_v + 16'd1;
        end else begin
            r_h <= r_h + 16'd1;
        end
    end

    // Bar index tracks h/BAR_W with a sub-counter instead of a divider;
    // it saturates at 7 so any remainder pixels join the last bar.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_barCnt <= 16'd0;
            r_barIdx <= 3'd0;
        end else if (w_hLast) begin
            r_barCnt <= 16'd0;
            r_barIdx <= 3'd0;
        end else if (r_barCnt == BAR_LAST) begin
            r_barCnt <= 16'd0;
            if (r_barIdx != 3'd7) begin
                r_barIdx <= r_barIdx + 3'd1;
            end
        end else begin
            r_barCnt <= r_barCnt + 16'd1;
        end
    end

    // Frame counter steps together with the wrap back to (0,0) so the
    // origin pixel carries the new frame number.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frameCnt <= 16'd0;
        end else if (w_hLast && w_vLast) begin
            r_frameCnt <= r_frameCnt + 16'd1;
        end
    end

    // Pattern controls are only captured at the origin
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_modeQ   <= MODE_NOISE;
            r_freezeQ <= 1'b0;
        end else if (w_origin) begin
            r_modeQ   <= mode_e'(mode);
            r_freezeQ <= freeze;
        end
    end

    assign w_lfsrLoad = w_origin && w_freezeEff;

    lfsr32 #(
        .RESET_VALUE(SEED_EFF)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .load   (w_lfsrLoad),
        .advance(w_visible),
        .seed   (SEED_EFF),
        .value  (w_lfsrValue)
    );

    // Value seen by the current pixel, before this pixel's advance
    assign w_lfsrCur  = w_lfsrLoad ? SEED_EFF : w_lfsrValue;

    assign w_hWide    = {16'h0, r_h};
    assign w_vWide    = {16'h0, r_v};
    assign w_barColor = 3'd7 - r_barIdx;
    assign w_checkBit = w_hWide[CELL_LOG2] ^ w_vWide[CELL_LOG2];

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_visible) begin
            case (w_modeEff)
                MODE_NOISE: begin
                    w_r = COLOR_BITS'(w_lfsrCur);
                    w_g = COLOR_BITS'(w_lfsrCur >> COLOR_BITS);
                    w_b = COLOR_BITS'(w_lfsrCur >> (2 * COLOR_BITS));
                end
                MODE_BARS: begin
                    w_r = w_barColor[2] ? FULL : '0;
                    w_g = w_barColor[1] ? FULL : '0;
                    w_b = w_barColor[0] ? FULL : '0;
                end
                MODE_CHECK: begin
                    w_r = w_checkBit ? '0 : FULL;
                    w_g = w_checkBit ? '0 : FULL;
                    w_b = w_checkBit ? '0 : FULL;
                end
                MODE_RAMP: begin
                    w_r = COLOR_BITS'(w_hWide >> RAMP_SHIFT);
                    w_g = COLOR_BITS'(w_hWide >> RAMP_SHIFT);
                    w_b = COLOR_BITS'(w_hWide >> RAMP_SHIFT);
                end
                default: begin
                    w_r = '0;
                    w_g = '0;
                    w_b = '0;
                end
            endcase
        end
    end

    // Output register stage; every output is aligned to the same pixel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            R           <= '0;
            G           <= '0;
            B           <= '0;
            de          <= 1'b0;
            x           <= 16'd0;
            y           <= 16'd0;
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            frame_start <= 1'b0;
            frame       <= 16'd0;
        end else begin
            R           <= w_r;
            G           <= w_g;
            B           <= w_b;
            de          <= w_visible;
            x           <= r_h;
            y           <= r_v;
            HS          <= w_hsActive ? HS_POL : ~HS_POL;
            VS          <= w_vsActive ? VS_POL : ~VS_POL;
            frame_start <= w_origin;
            frame       <= r_frameCnt;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
// Drives a full-width (640-pixel) generator with a shortened vertical
// timing and a tiny active-high-sync generator side by side. A behavioural
// raster model pushes the expected output of every pixel into a queue; the
// main DUT outputs are popped and compared half a clock later. A table of
// hand-computed pixel values and a few multi-frame sequences cover modes,
// mode/freeze capture, noise repeatability and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

   localparam int MH_VIS   = 640;
   localparam int MH_TOT   = 800;
   localparam int MV_VIS   = 9;
   localparam int MV_TOT   = 12;
   localparam int MVS_LINE = 10;
   localparam int FRAME_CYCLES = MH_TOT * MV_TOT;
   localparam logic [31:0] SEED = 32'hACE11234;

   typedef struct packed {
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic        hs;
      logic        vs;
      logic        de;
      logic [15:0] x;
      logic [15:0] y;
      logic        fs;
      logic [15:0] frame;
   } pix_t;

   typedef struct {
      logic [1:0] mode;
      logic       freeze;
      logic       settle;
      int         h;
      int         v;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      logic       de;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [1:0] mode = 2'd1;
   logic freeze = 1'b0;

   logic [3:0]  R, G, B;
   logic        HS, VS, de, frame_start;
   logic [15:0] x, y, frame;

   logic [3:0]  tR, tG, tB;
   logic        tHS, tVS, tde, tFrameStart;
   logic [15:0] tx, ty, tFrame;

   int assertCount = 0;
   int failCount   = 0;
   bit monOn = 1'b1;

   pix_t sbQ[$];

   always #5 clock = ~clock;

   vga_pattern_gen #(
      .V_VISIBLE(MV_VIS),
      .V_FRONT  (1),
      .V_SYNC   (1),
      .V_BACK   (1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .mode       (mode),
      .freeze     (freeze),
      .R          (R),
      .G          (G),
      .B          (B),
      .HS         (HS),
      .VS         (VS),
      .de         (de),
      .x          (x),
      .y          (y),
      .frame_start(frame_start),
      .frame      (frame)
   );

   vga_pattern_gen #(
      .H_VISIBLE(8),
      .H_FRONT  (1),
      .H_SYNC   (2),
      .H_BACK   (1),
      .V_VISIBLE(4),
      .V_FRONT  (1),
      .V_SYNC   (1),
      .V_BACK   (1),
      .HS_POL   (1'b1),
      .VS_POL   (1'b1)
   ) dutTiny (
      .clock      (clock),
      .reset      (reset),
      .mode       (2'd1),
      .freeze     (1'b0),
      .R          (tR),
      .G          (tG),
      .B          (tB),
      .HS         (tHS),
      .VS         (tVS),
      .de         (tde),
      .x          (tx),
      .y          (ty),
      .frame_start(tFrameStart),
      .frame      (tFrame)
   );

   // Counts one comparison and reports it when actual differs from expected
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reportTimeout(input string name);
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: timeout waiting for DUT at %0t", name, $time);
   endtask

   function automatic logic [31:0] galoisNext(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 32'h80200003;
      return n;
   endfunction

   // Behavioural raster model for the main DUT: one expected pixel per edge
   int mh, mv;
   logic [31:0] mLfsr;
   logic [1:0]  mModeQ;
   logic        mFreezeQ;
   logic [15:0] mFrame;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mh = 0;
         mv = 0;
         mLfsr = SEED;
         mModeQ = 2'd0;
         mFreezeQ = 1'b0;
         mFrame = 16'd0;
         sbQ.delete();
      end else begin
         pix_t e;
         logic origin, vis, effFreeze;
         logic [1:0] effMode;
         logic [31:0] cur;
         int bi;
         logic [2:0] c;
         origin = (mh == 0) && (mv == 0);
         effMode = origin ? mode : mModeQ;
         effFreeze = origin ? freeze : mFreezeQ;
         if (origin) begin
            mModeQ = mode;
            mFreezeQ = freeze;
         end
         vis = (mh < MH_VIS) && (mv < MV_VIS);
         cur = (origin && effFreeze) ? SEED : mLfsr;
         e = '0;
         if (vis) begin
            case (effMode)
               2'd0: begin
                  e.r = cur[3:0];
                  e.g = cur[7:4];
                  e.b = cur[11:8];
               end
               2'd1: begin
                  bi = mh / (MH_VIS / 8);
                  if (bi > 7) bi = 7;
                  c = 3'(7 - bi);
                  e.r = c[2] ? 4'hF : 4'h0;
                  e.g = c[1] ? 4'hF : 4'h0;
                  e.b = c[0] ? 4'hF : 4'h0;
               end
               2'd2: begin
                  e.r = (((mh / 8) + (mv / 8)) % 2 == 0) ? 4'hF : 4'h0;
                  e.g = e.r;
                  e.b = e.r;
               end
               default: begin
                  e.r = 4'((mh / 32) % 16);
                  e.g = e.r;
                  e.b = e.r;
               end
            endcase
         end
         e.de = vis;
         e.hs = (mh >= 656 && mh < 752) ? 1'b0 : 1'b1;
         e.vs = (mv == MVS_LINE) ? 1'b0 : 1'b1;
         e.x = 16'(mh);
         e.y = 16'(mv);
         e.fs = origin;
         e.frame = mFrame;
         sbQ.push_back(e);
         if (vis) mLfsr = galoisNext(cur);
         mh++;
         if (mh == MH_TOT) begin
            mh = 0;
            mv++;
            if (mv == MV_TOT) begin
               mv = 0;
               mFrame++;
            end
         end
      end
   end

   // Scoreboard: compare every main DUT pixel against the model
   always @(negedge clock) begin
      if (!reset && sbQ.size() > 0) begin
         pix_t exp, act;
         exp = sbQ.pop_front();
         act = {R, G, B, HS, VS, de, x, y, frame_start, frame};
         checkOutput("scoreboard", act, exp);
      end
   end

   // Sync and active-video shape of the main DUT
   int cycle = 0;
   int hsRun = 0, vsRun = 0, deRun = 0, deLines = 0, lastHsStart = -1;
   bit prevHs = 0, prevVs = 0, prevDe = 0, seenFrame = 0;

   always @(negedge clock) begin
      cycle++;
      if (monOn && !reset) begin
         if (frame_start) begin
            if (seenFrame) checkOutput("deLinesPerFrame", 64'(deLines), 64'(MV_VIS));
            seenFrame = 1;
            deLines = 0;
         end
         if (!HS) begin
            if (!prevHs) begin
               checkOutput("hsStartX", 64'(x), 64'd656);
               if (lastHsStart >= 0) checkOutput("hsPeriod", 64'(cycle - lastHsStart), 64'd800);
               lastHsStart = cycle;
               hsRun = 0;
            end
            hsRun++;
         end else if (prevHs) begin
            checkOutput("hsWidth", 64'(hsRun), 64'd96);
         end
         if (!VS) begin
            if (!prevVs) begin
               checkOutput("vsStart", 64'({x, y}), 64'({16'd0, 16'(MVS_LINE)}));
               vsRun = 0;
            end
            vsRun++;
         end else if (prevVs) begin
            checkOutput("vsWidth", 64'(vsRun), 64'd800);
         end
         if (de) begin
            if (!prevDe) begin
               deRun = 0;
               deLines++;
            end
            deRun++;
         end else if (prevDe) begin
            checkOutput("deWidth", 64'(deRun), 64'(MH_VIS));
         end
         prevHs = !HS;
         prevVs = !VS;
         prevDe = de;
      end
   end

   // Tiny generator: active-high syncs, 1-pixel bars, frame stepping
   bit tValid = 0;
   int th = 0, tv = 0;
   logic [15:0] tExpFrame = 16'd0;

   always @(negedge clock) begin
      if (reset) begin
         tValid = 0;
         tExpFrame = 16'd0;
      end else begin
         if (!tValid) begin
            if (tFrameStart) begin
               tValid = 1;
               th = 0;
               tv = 0;
            end
         end else begin
            th++;
            if (th == 12) begin
               th = 0;
               tv++;
               if (tv == 7) begin
                  tv = 0;
                  tExpFrame++;
               end
            end
         end
         if (tValid) begin
            pix_t e, act;
            logic [2:0] c;
            e = '0;
            e.de = (th < 8) && (tv < 4);
            if (e.de) begin
               c = 3'(7 - th);
               e.r = c[2] ? 4'hF : 4'h0;
               e.g = c[1] ? 4'hF : 4'h0;
               e.b = c[0] ? 4'hF : 4'h0;
            end
            e.hs = (th == 9) || (th == 10);
            e.vs = (tv == 5);
            e.x = 16'(th);
            e.y = 16'(tv);
            e.fs = (th == 0) && (tv == 0);
            e.frame = tExpFrame;
            act = {tR, tG, tB, tHS, tVS, tde, tx, ty, tFrameStart, tFrame};
            checkOutput("tinyPixel", act, e);
         end
      end
   end

   task automatic waitFrameStart(input string name);
      for (int n = 0; n < FRAME_CYCLES + 20; n++) begin
         @(negedge clock);
         if (frame_start) return;
      end
      reportTimeout(name);
   endtask

   task automatic waitPixel(input string name, input int h, input int v);
      for (int n = 0; n < 2 * FRAME_CYCLES; n++) begin
         if (x == 16'(h) && y == 16'(v)) return;
         @(negedge clock);
      end
      reportTimeout(name);
   endtask

   task automatic applyStimulus(input vec_t vec, input int idx);
      string name;
      name = $sformatf("vec%0d(%0d,%0d)", idx, vec.h, vec.v);
      mode = vec.mode;
      freeze = vec.freeze;
      if (vec.settle) waitFrameStart(name);
      waitPixel(name, vec.h, vec.v);
      checkOutput(name, 64'({R, G, B, de}), 64'({vec.r, vec.g, vec.b, vec.de}));
   endtask

   // Signature of one frame's visible colours, from frame_start to the next
   task automatic frameSig(input string name, output logic [31:0] sig);
      sig = 32'h1;
      for (int n = 0; n < FRAME_CYCLES + 20; n++) begin
         if (de) sig = {sig[26:0], sig[31:27]} ^ {20'h0, R, G, B};
         @(negedge clock);
         if (frame_start) return;
      end
      reportTimeout(name);
   endtask

   vec_t vecs[19];

   initial begin
      logic [31:0] sigA, sigB, sigC;

      vecs[0]  = '{2'd1, 1'b0, 1'b1,   0, 0, 4'hF, 4'hF, 4'hF, 1'b1};
      vecs[1]  = '{2'd1, 1'b0, 1'b0,  80, 0, 4'hF, 4'hF, 4'h0, 1'b1};
      vecs[2]  = '{2'd1, 1'b0, 1'b0, 639, 0, 4'h0, 4'h0, 4'h0, 1'b1};
      vecs[3]  = '{2'd1, 1'b0, 1'b0, 700, 0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[4]  = '{2'd1, 1'b0, 1'b0,  80, 5, 4'hF, 4'hF, 4'h0, 1'b1};
      vecs[5]  = '{2'd2, 1'b0, 1'b0,  80, 7, 4'hF, 4'hF, 4'h0, 1'b1};
      vecs[6]  = '{2'd2, 1'b0, 1'b1,   0, 0, 4'hF, 4'hF, 4'hF, 1'b1};
      vecs[7]  = '{2'd2, 1'b0, 1'b0,   7, 0, 4'hF, 4'hF, 4'hF, 1'b1};
      vecs[8]  = '{2'd2, 1'b0, 1'b0,   8, 0, 4'h0, 4'h0, 4'h0, 1'b1};
      vecs[9]  = '{2'd2, 1'b0, 1'b0,   0, 8, 4'h0, 4'h0, 4'h0, 1'b1};
      vecs[10] = '{2'd2, 1'b0, 1'b0,   8, 8, 4'hF, 4'hF, 4'hF, 1'b1};
      vecs[11] = '{2'd3, 1'b0, 1'b0,  40, 8, 4'hF, 4'hF, 4'hF, 1'b1};
      vecs[12] = '{2'd3, 1'b0, 1'b1,   0, 0, 4'h0, 4'h0, 4'h0, 1'b1};
      vecs[13] = '{2'd3, 1'b0, 1'b0,  32, 0, 4'h1, 4'h1, 4'h1, 1'b1};
      vecs[14] = '{2'd3, 1'b0, 1'b0, 511, 0, 4'hF, 4'hF, 4'hF, 1'b1};
      vecs[15] = '{2'd3, 1'b0, 1'b0, 639, 3, 4'h3, 4'h3, 4'h3, 1'b1};
      vecs[16] = '{2'd0, 1'b1, 1'b1,   0, 0, 4'h4, 4'h3, 4'h2, 1'b1};
      vecs[17] = '{2'd0, 1'b1, 1'b0,   1, 0, 4'hA, 4'h1, 4'h9, 1'b1};
      vecs[18] = '{2'd0, 1'b1, 1'b0,   2, 0, 4'hD, 4'h8, 4'h4, 1'b1};

      // Reset values while reset is held
      repeat (3) @(negedge clock);
      checkOutput("resetHold", 64'({R, G, B, HS, VS, de, x, y, frame_start, frame}),
                  64'({12'h0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0}));
      reset = 1'b0;
      @(negedge clock);
      checkOutput("firstFrameStart", 64'({frame_start, x, y, frame}), 64'({1'b1, 16'd0, 16'd0, 16'd0}));

      for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

      // Two frozen-noise frames repeat exactly; releasing freeze breaks that
      waitFrameStart("frozenA");
      frameSig("frozenA", sigA);
      freeze = 1'b0;
      frameSig("frozenB", sigB);
      frameSig("liveC", sigC);
      checkOutput("frozenRepeat", 64'(sigA), 64'(sigB));
      checkOutput("liveDiffers", 64'(sigB != sigC), 64'd1);

      // Asynchronous reset in the middle of a line
      waitPixel("midLine", 100, 2);
      monOn = 1'b0;
      #1 reset = 1'b1;
      #1;
      checkOutput("asyncResetMain", 64'({R, G, B, HS, VS, de, x, y, frame_start, frame}),
                  64'({12'h0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0}));
      checkOutput("asyncResetTiny", 64'({tHS, tVS, tde, tFrameStart, tFrame}), 64'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("restartOrigin", 64'({frame_start, x, y, frame, de}),
                  64'({1'b1, 16'd0, 16'd0, 16'd0, 1'b1}));

      repeat (2000) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
